// File: rtl/sensor_cipher_sequencer_if.sv
// Cipher start/done handshake and 64-bit UART send handshake for the telemetry sequencer.
// master = sequencer side, slave = cipher core plus UART sender side.
interface sensor_cipher_sequencer_if;
    logic        enc_start;
    logic [63:0] enc_in;
    logic        enc_done;
    logic [63:0] enc_out;
    logic        uart_en;
    logic [63:0] uart_din;
    logic        uart_tx_busy;

    modport master (
        output enc_start, enc_in, uart_en, uart_din,
        input  enc_done, enc_out, uart_tx_busy
    );

    modport slave (
        input  enc_start, enc_in, uart_en, uart_din,
        output enc_done, enc_out, uart_tx_busy
    );
endinterface

// File: rtl/sensor_cipher_sequencer.sv
// Frame sequencer: once per period it samples the temperature, encrypts a 64-bit frame and
// sends the ciphertext over UART; cipher hangs and dropped ticks are recorded, never waited on.
module sensor_cipher_sequencer #(
    parameter int TICK_CYCLES = 10_000_000,
    parameter int ENC_TIMEOUT = 1024,
    parameter int BUSY_WAIT   = 16
) (
    input  logic                             CLK100MHZ,
    input  logic                             CPU_RESETN,
    input  logic [19:0]                      temp_data,
    sensor_cipher_sequencer_if.master        bus,
    output logic [31:0]                      disp_data,
    output logic [15:0]                      seq_num,
    output logic [7:0]                       overrun_cnt,
    output logic                             enc_err
);
    localparam int TICK_W = $clog2(TICK_CYCLES);
    localparam int TO_W   = $clog2(ENC_TIMEOUT + 1);
    localparam int BW_W   = $clog2(BUSY_WAIT + 1);

    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_CYCLES - 1);
    localparam logic [TO_W-1:0]   TO_LAST   = TO_W'(ENC_TIMEOUT - 1);
    localparam logic [BW_W-1:0]   BW_LAST   = BW_W'(BUSY_WAIT - 1);

    typedef enum logic [2:0] {
        IDLE,
        LAUNCH,
        ENC_WAIT,
        TX_REQ,
        TX_ARM,
        TX_BUSY
    } state_t;

    state_t            state;
    logic [TICK_W-1:0] tick_cnt;
    logic              tick;
    logic [TO_W-1:0]   timeout_cnt;
    logic [BW_W-1:0]   wait_cnt;
    logic [15:0]       seq_next;

    assign tick     = (tick_cnt == TICK_LAST);
    assign seq_next = seq_num + 16'd1;

    always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
        if (!CPU_RESETN) begin
            tick_cnt <= '0;
        end else if (tick) begin
            tick_cnt <= '0;
        end else begin
            tick_cnt <= tick_cnt + TICK_W'(1);
        end
    end

    always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
        if (!CPU_RESETN) begin
            overrun_cnt <= '0;
        end else if (tick && (state != IDLE) && (overrun_cnt != 8'hFF)) begin
            overrun_cnt <= overrun_cnt + 8'd1;
        end
    end

    // timeout_cnt counts cycles since enc_start, so a hung cipher is abandoned
    // exactly ENC_TIMEOUT cycles after launch; the same holds for wait_cnt after uart_en.
    always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
        if (!CPU_RESETN) begin
            state         <= IDLE;
            bus.enc_start <= 1'b0;
            bus.enc_in    <= '0;
            bus.uart_en   <= 1'b0;
            bus.uart_din  <= '0;
            disp_data     <= '0;
            seq_num       <= '0;
            enc_err       <= 1'b0;
            timeout_cnt   <= '0;
            wait_cnt      <= '0;
        end else begin
            bus.enc_start <= 1'b0;
            bus.uart_en   <= 1'b0;
            case (state)
                IDLE: begin
                    if (tick) begin
                        bus.enc_in    <= {seq_next, 28'h0, temp_data};
                        bus.enc_start <= 1'b1;
                        timeout_cnt   <= '0;
                        state         <= LAUNCH;
                    end
                end
                LAUNCH: begin
                    timeout_cnt <= timeout_cnt + TO_W'(1);
                    state       <= ENC_WAIT;
                end
                ENC_WAIT: begin
                    if (bus.enc_done) begin
                        bus.uart_din <= bus.enc_out;
                        // An idle UART is requested straight away rather than via TX_REQ,
                        // giving uart_en one cycle after enc_done.
                        if (!bus.uart_tx_busy) begin
                            bus.uart_en <= 1'b1;
                            wait_cnt    <= '0;
                            state       <= TX_ARM;
                        end else begin
                            state <= TX_REQ;
                        end
                    end else if (timeout_cnt == TO_LAST) begin
                        enc_err <= 1'b1;
                        state   <= IDLE;
                    end else begin
                        timeout_cnt <= timeout_cnt + TO_W'(1);
                    end
                end
                TX_REQ: begin
                    if (!bus.uart_tx_busy) begin
                        bus.uart_en <= 1'b1;
                        wait_cnt    <= '0;
                        state       <= TX_ARM;
                    end
                end
                TX_ARM: begin
                    if (bus.uart_tx_busy) begin
                        state <= TX_BUSY;
                    end else if (wait_cnt == BW_LAST) begin
                        disp_data <= bus.uart_din[31:0];
                        seq_num   <= bus.enc_in[63:48];
                        state     <= IDLE;
                    end else begin
                        wait_cnt <= wait_cnt + BW_W'(1);
                    end
                end
                TX_BUSY: begin
                    if (!bus.uart_tx_busy) begin
                        disp_data <= bus.uart_din[31:0];
                        seq_num   <= bus.enc_in[63:48];
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
